// File: rtl/uart_bus_master.sv
// -----------------------------------------------------------------------------
// uart_bus_master
//
// Debug bus initiator. It parses command frames from a UART receiver and
// issues single read/write transactions on the J1-style peripheral I/O bus,
// next to the CPU (an external mux selects between the two masters). Replies
// go back through a UART transmitter.
//
//   'W' AH AL DH DL  -> one io_wr cycle, reply 'K'
//   'R' AH AL        -> one io_rd cycle, reply DH then DL
//
// Optional feature macro: UBM_CHECKSUM_EN
//   When defined, a checksum byte CK follows the last payload byte. CK is the
//   8-bit sum of every preceding byte of the frame, including the opcode. A bad
//   CK suppresses the bus access and the reply is 'E'.
//
// Parameters
//   RD_LAT       cycles from the io_rd cycle to the io_din sample (0 = same cycle)
//   TIMEOUT_CYC  idle cycles allowed between the bytes of a frame (0 = never)
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   rx_data/valid  received byte; rx_valid is a one-cycle pulse
//   tx_data/start  byte and one-cycle request pulse to the transmitter
//   tx_busy        transmitter busy; rises the cycle after tx_start
//   io_addr        bus address ([15:8] feeds the chip-select decode)
//   io_dout        write data
//   io_rd, io_wr   one-cycle strobes, never high together
//   io_din         read data from the peripheral mux
//   busy           high whenever the block is not idle
// -----------------------------------------------------------------------------
module uart_bus_master #(
    parameter int RD_LAT      = 0,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [15:0] io_addr,
    output logic [15:0] io_dout,
    output logic        io_rd,
    output logic        io_wr,
    input  logic [15:0] io_din,
    output logic        busy
);

`ifdef UBM_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    localparam logic [7:0] OP_WR  = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RPL_OK = 8'h4B;  // 'K'
    localparam logic [7:0] RPL_ER = 8'h45;  // 'E'

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        DATA_H,
        DATA_L,
        CHECK,
        BUS_WR,
        BUS_RD,
        RD_WAIT,
        TX0,
        TX0_GAP,
        TX1,
        TX1_GAP,
        TX_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic [15:0]        dout_q, dout_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               is_rd_q, is_rd_d;
    logic               err_q, err_d;
    logic [7:0]         sum_q, sum_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

    logic               in_parse;
    logic               timeout_hit;
    logic [7:0]         byte0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
            is_rd_q   <= 1'b0;
            err_q     <= 1'b0;
            sum_q     <= '0;
            to_cnt_q  <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            is_rd_q   <= is_rd_d;
            err_q     <= err_d;
            sum_q     <= sum_d;
            to_cnt_q  <= to_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign in_parse = (state_q == ADDR_H) || (state_q == ADDR_L) ||
                      (state_q == DATA_H) || (state_q == DATA_L) ||
                      (state_q == CHECK);

    // Abort fires on the idle cycle that brings the count to TIMEOUT_CYC.
    assign timeout_hit = (TIMEOUT_CYC != 0) && in_parse && !rx_valid &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    assign byte0 = err_q   ? RPL_ER :
                   is_rd_q ? rdata_q[15:8] : RPL_OK;

    assign io_addr = addr_q;
    assign io_dout = dout_q;
    assign busy    = (state_q != IDLE);

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rdata_d   = rdata_q;
        is_rd_d   = is_rd_q;
        err_d     = err_q;
        sum_d     = sum_q;
        to_cnt_d  = to_cnt_q;
        lat_cnt_d = lat_cnt_q;
        io_rd     = 1'b0;
        io_wr     = 1'b0;
        tx_start  = 1'b0;
        tx_data   = 8'h00;

        // Inter-byte idle counter: runs only inside a frame.
        if (!in_parse || rx_valid || TIMEOUT_CYC == 0) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) begin
                    is_rd_d = (rx_data == OP_RD);
                    err_d   = 1'b0;
                    sum_d   = rx_data;
                    state_d = ADDR_H;
                end
            end
            ADDR_H: begin
                if (rx_valid) begin
                    addr_d[15:8] = rx_data;
                    sum_d        = sum_q + rx_data;
                    state_d      = ADDR_L;
                end
            end
            ADDR_L: begin
                if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    sum_d       = sum_q + rx_data;
                    if (is_rd_q) state_d = CK_EN ? CHECK : BUS_RD;
                    else         state_d = DATA_H;
                end
            end
            DATA_H: begin
                if (rx_valid) begin
                    dout_d[15:8] = rx_data;
                    sum_d        = sum_q + rx_data;
                    state_d      = DATA_L;
                end
            end
            DATA_L: begin
                if (rx_valid) begin
                    dout_d[7:0] = rx_data;
                    sum_d       = sum_q + rx_data;
                    state_d     = CK_EN ? CHECK : BUS_WR;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        state_d = is_rd_q ? BUS_RD : BUS_WR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = TX0;
                    end
                end
            end
            BUS_WR: begin
                io_wr   = 1'b1;
                state_d = TX0;
            end
            BUS_RD: begin
                io_rd = 1'b1;
                if (RD_LAT == 0) begin
                    rdata_d = io_din;
                    state_d = TX0;
                end else begin
                    lat_cnt_d = LAT_W'(1);
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // io_addr is untouched here, so it stays valid through the sample.
                if (lat_cnt_q == LAT_W'(RD_LAT)) begin
                    rdata_d = io_din;
                    state_d = TX0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            TX0: begin
                tx_data = byte0;
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = TX0_GAP;
                end
            end
            TX0_GAP: begin
                // One cycle for the transmitter to raise tx_busy.
                tx_data = byte0;
                state_d = (is_rd_q && !err_q) ? TX1 : TX_DONE;
            end
            TX1: begin
                tx_data = rdata_q[7:0];
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = TX1_GAP;
                end
            end
            TX1_GAP: begin
                tx_data = rdata_q[7:0];
                state_d = TX_DONE;
            end
            TX_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_master
//
// Directed bench for uart_bus_master. Two instances share the receive stream
// and io_din: u_dut0 (RD_LAT=0) and u_dut2 (RD_LAT=2), both TIMEOUT_CYC=100.
// Each has its own transmitter model that holds tx_busy for four cycles after
// tx_start. With UBM_CHECKSUM_EN defined the frame tasks append the checksum
// and the checksum-error frame is exercised as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] io_din;

    logic [7:0]  tx_data0, tx_data2;
    logic        tx_start0, tx_start2;
    logic        tx_busy0, tx_busy2;
    logic [15:0] io_addr0, io_addr2, io_dout0, io_dout2;
    logic        io_rd0, io_rd2, io_wr0, io_wr2;
    logic        busy0, busy2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_bus_master #(.RD_LAT(0), .TIMEOUT_CYC(100)) u_dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data0), .tx_start(tx_start0), .tx_busy(tx_busy0),
        .io_addr(io_addr0), .io_dout(io_dout0), .io_rd(io_rd0), .io_wr(io_wr0),
        .io_din(io_din), .busy(busy0)
    );

    uart_bus_master #(.RD_LAT(2), .TIMEOUT_CYC(100)) u_dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(tx_busy2),
        .io_addr(io_addr2), .io_dout(io_dout2), .io_rd(io_rd2), .io_wr(io_wr2),
        .io_din(io_din), .busy(busy2)
    );

    // Transmitter models: busy rises the cycle after tx_start, lasts 4 cycles.
    logic [2:0] txc0, txc2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txc0 <= '0;
            txc2 <= '0;
        end else begin
            txc0 <= tx_start0 ? 3'd4 : (txc0 != 0 ? txc0 - 3'd1 : 3'd0);
            txc2 <= tx_start2 ? 3'd4 : (txc2 != 0 ? txc2 - 3'd1 : 3'd0);
        end
    end
    assign tx_busy0 = (txc0 != 0);
    assign tx_busy2 = (txc2 != 0);

    // Monitors sample on the falling edge.
    logic [7:0] q0[$];
    logic [7:0] q2[$];
    int rd0 = 0, rd2 = 0, wr0 = 0, wr2 = 0, viol = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start0) q0.push_back(tx_data0);
            if (tx_start2) q2.push_back(tx_data2);
            if (io_rd0) rd0++;
            if (io_rd2) rd2++;
            if (io_wr0) wr0++;
            if (io_wr2) wr2++;
            if ((tx_start0 && tx_busy0) || (tx_start2 && tx_busy2)) viol++;
            if ((io_rd0 && io_wr0) || (io_rd2 && io_wr2)) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int which, input int idx);
        if (which == 0) return (q0.size() > idx) ? {24'h0, q0[idx]} : 32'hFFFF_FFFF;
        else            return (q2.size() > idx) ? {24'h0, q2[idx]} : 32'hFFFF_FFFF;
    endfunction

    // Byte is valid for exactly one cycle; returns #1 into the following cycle.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy0 || busy2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", {31'h0, k < 200}, 32'h1);
    endtask

    task automatic read_cmd(input logic [15:0] addr, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [15:0] d2);
        int b0 = q0.size();
        int b2 = q2.size();
        int r0 = rd0;
        int r2 = rd2;
        send_byte(8'h52);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
`ifdef UBM_CHECKSUM_EN
        send_byte(8'h52 + addr[15:8] + addr[7:0]);
`endif
        io_din = d0;                       // cycle N+1: the io_rd cycle
        @(negedge clk);
        check("rd_strobe0", {31'h0, io_rd0}, 32'h1);
        check("rd_strobe2", {31'h0, io_rd2}, 32'h1);
        check("rd_addr", {16'h0, io_addr0}, {16'h0, addr});
        check("rd_no_wr", {31'h0, io_wr0}, 32'h0);
        @(posedge clk); #1;
        io_din = d1;                       // cycle N+2: must not be captured
        @(negedge clk);
        check("rd_one_cycle", {30'h0, io_rd0, io_rd2}, 32'h0);
        check("rd_addr_hold", {16'h0, io_addr2}, {16'h0, addr});
        @(posedge clk); #1;
        io_din = d2;                       // cycle N+3: RD_LAT=2 sample
        @(posedge clk); #1;
        io_din = 16'h0000;
        wait_idle();
        check("rd_count0", rd0 - r0, 32'd1);
        check("rd_count2", rd2 - r2, 32'd1);
        check("rd_txn0", q0.size() - b0, 32'd2);
        check("rd_tx0_hi", qget(0, b0),     {24'h0, d0[15:8]});
        check("rd_tx0_lo", qget(0, b0 + 1), {24'h0, d0[7:0]});
        check("rd_tx2_hi", qget(2, b2),     {24'h0, d2[15:8]});
        check("rd_tx2_lo", qget(2, b2 + 1), {24'h0, d2[7:0]});
    endtask

    task automatic write_cmd(input logic [15:0] addr, input logic [15:0] data);
        int b0 = q0.size();
        int b2 = q2.size();
        int w0 = wr0;
        int w2 = wr2;
        send_byte(8'h57);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        send_byte(data[15:8]);
        send_byte(data[7:0]);
`ifdef UBM_CHECKSUM_EN
        send_byte(8'h57 + addr[15:8] + addr[7:0] + data[15:8] + data[7:0]);
`endif
        @(negedge clk);
        check("wr_strobe0", {31'h0, io_wr0}, 32'h1);
        check("wr_strobe2", {31'h0, io_wr2}, 32'h1);
        check("wr_addr", {16'h0, io_addr0}, {16'h0, addr});
        check("wr_data", {16'h0, io_dout0}, {16'h0, data});
        check("wr_no_rd", {31'h0, io_rd0}, 32'h0);
        @(negedge clk);
        check("wr_one_cycle", {30'h0, io_wr0, io_wr2}, 32'h0);
        wait_idle();
        check("wr_count0", wr0 - w0, 32'd1);
        check("wr_count2", wr2 - w2, 32'd1);
        check("wr_txn", q0.size() - b0, 32'd1);
        check("wr_tx0", qget(0, b0), 32'h4B);
        check("wr_tx2", qget(2, b2), 32'h4B);
        check("wr_addr_held", {16'h0, io_addr0}, {16'h0, addr});
        check("wr_data_held", {16'h0, io_dout0}, {16'h0, data});
    endtask

    initial begin
        int b0, r0, w0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        io_din   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_strobes", {28'h0, io_rd0, io_wr0, tx_start0, busy0}, 32'h0);
        check("rst_addr", {16'h0, io_addr0}, 32'h0);
        check("rst_dout", {16'h0, io_dout0}, 32'h0);
        check("rst_txdata", {24'h0, tx_data0}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during ADDR_L.
        send_byte(8'h52);
        send_byte(8'h69);
        check("mid_busy", {31'h0, busy0}, 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {30'h0, busy0, busy2}, 32'h0);
        check("mid_rst_addr", {16'h0, io_addr0}, 32'h0);
        check("mid_rst_strb", {28'h0, io_rd0, io_wr0, tx_start0, io_rd2}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_no_strobe", rd0 + wr0 + q0.size(), 32'd0);
        read_cmd(16'h6900, 16'h1234, 16'hAAAA, 16'h5678);

        write_cmd(16'h6700, 16'h1234);
        read_cmd(16'h7005, 16'hBEEF, 16'h1111, 16'h2222);

        // Bytes arriving during the bus/TX phase are dropped.
        b0 = q0.size();
        r0 = rd0;
        send_byte(8'h57); send_byte(8'h6A); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01);
`ifdef UBM_CHECKSUM_EN
        send_byte(8'h57 + 8'h6A + 8'h01);
`endif
        send_byte(8'h52); send_byte(8'h6A); send_byte(8'h00);
        wait_idle();
        repeat (5) @(negedge clk);
        check("drop_no_rd", rd0 - r0, 32'd0);
        check("drop_busy", {31'h0, busy0}, 32'h0);
        check("drop_txn", q0.size() - b0, 32'd1);

        // Junk byte, then an abandoned frame that must time out.
        b0 = q0.size();
        r0 = rd0;
        w0 = wr0;
        send_byte(8'h41);
        @(negedge clk);
        check("junk_idle", {31'h0, busy0}, 32'h0);
        send_byte(8'h57);
        send_byte(8'h68);
        repeat (50) @(negedge clk);
        check("to_still_busy", {31'h0, busy0}, 32'h1);
        repeat (55) @(negedge clk);
        check("to_idle", {30'h0, busy0, busy2}, 32'h0);
        check("to_no_strobe", (rd0 - r0) + (wr0 - w0), 32'd0);
        check("to_no_tx", q0.size() - b0, 32'd0);
        // Recovery; opcode values in data positions are plain data.
        write_cmd(16'h6800, 16'h5257);

`ifdef UBM_CHECKSUM_EN
        b0 = q0.size();
        r0 = rd0;
        send_byte(8'h52); send_byte(8'h69); send_byte(8'h00); send_byte(8'hBC);
        @(negedge clk);
        check("ck_bad_no_rd", {31'h0, io_rd0}, 32'h0);
        wait_idle();
        check("ck_bad_rdcnt", rd0 - r0, 32'd0);
        check("ck_bad_txn", q0.size() - b0, 32'd1);
        check("ck_bad_reply", qget(0, b0), 32'h45);
`endif

        check("protocol_viol", viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
